// File: rtl/sync_counter.sv
// Free-running modulo-MODULUS up-counter with a terminal-count decode and a
// registered wrap pulse, usable as a timebase or sequence generator.
module sync_counter #(
    parameter int unsigned     WIDTH       = 4,
    parameter longint unsigned MODULUS     = 64'd1 << WIDTH,
    parameter longint unsigned RESET_VALUE = 64'd0
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    // MODULUS is 64-bit so that WIDTH=32 with a full 2**32 modulus still fits.
    localparam logic [WIDTH-1:0] LAST_COUNT = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] RST_COUNT  = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] count_r;
    logic             wrap_r;
    logic [WIDTH-1:0] next_count_s;
    logic             at_last_s;

    // Next-state: advance by one, or fold back to zero from the last state.
    always_comb begin
        at_last_s    = 1'b0;
        next_count_s = count_r;
        if (count_r == LAST_COUNT) begin
            at_last_s    = 1'b1;
            next_count_s = '0;
        end else begin
            at_last_s    = 1'b0;
            next_count_s = count_r + WIDTH'(1'b1);
        end
    end

    // Count and wrap registers; reset forces the load value and clears wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= RST_COUNT;
            wrap_r  <= 1'b0;
        end else begin
            count_r <= next_count_s;
            wrap_r  <= at_last_s;
        end
    end

    assign count = count_r;
    assign wrap  = wrap_r;
    assign tc    = (count_r == LAST_COUNT);

endmodule

// File: tb/tb_sync_counter.sv
// Scoreboard bench for sync_counter: three instances (default, modulus 10,
// reset value 7) exercised one after another with directed expectations.
module tb_sync_counter;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    logic [3:0] cnt_a, cnt_b, cnt_c;
    logic tc_a, tc_b, tc_c, wrap_a, wrap_b, wrap_c;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        int         dut;
        logic [3:0] cnt;
        logic       tc;
        logic       wrap;
        string      name;
    } exp_t;

    exp_t sb[$];
    event sample_ev;

    always #5 clk = ~clk;

    sync_counter #(.WIDTH(4)) dut_a (
        .clk(clk), .reset(rst_a), .count(cnt_a), .tc(tc_a), .wrap(wrap_a));
    sync_counter #(.WIDTH(4), .MODULUS(64'd10)) dut_b (
        .clk(clk), .reset(rst_b), .count(cnt_b), .tc(tc_b), .wrap(wrap_b));
    sync_counter #(.WIDTH(4), .RESET_VALUE(64'd7)) dut_c (
        .clk(clk), .reset(rst_c), .count(cnt_c), .tc(tc_c), .wrap(wrap_c));

    task automatic expect_out(input int dut, input int c, input logic t,
                              input logic w, input string name);
        exp_t e;
        e.dut  = dut;
        e.cnt  = 4'(c);
        e.tc   = t;
        e.wrap = w;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic wait_neg();
        @(negedge clk);
        #1;
    endtask

    // Monitor: drains the scoreboard at each falling edge or on demand.
    initial begin
        exp_t e;
        logic [3:0] ac;
        logic at, aw;
        forever begin
            @(negedge clk or sample_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.dut)
                    0:       begin ac = cnt_a; at = tc_a; aw = wrap_a; end
                    1:       begin ac = cnt_b; at = tc_b; aw = wrap_b; end
                    default: begin ac = cnt_c; at = tc_c; aw = wrap_c; end
                endcase
                tests++;
                if (ac !== e.cnt || at !== e.tc || aw !== e.wrap) begin
                    failed++;
                    $display("FAIL %s dut%0d @%0t: got count=%0d tc=%b wrap=%b, expected count=%0d tc=%b wrap=%b",
                             e.name, e.dut, $time, ac, at, aw, e.cnt, e.tc, e.wrap);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;

        // Power-up reset holds across clock edges.
        for (int i = 0; i < 2; i++) begin
            expect_out(0, 0, 1'b0, 1'b0, "reset_hold_a");
            expect_out(1, 0, 1'b0, 1'b0, "reset_hold_b");
            expect_out(2, 7, 1'b0, 1'b0, "reset_hold_c");
            wait_neg();
        end

        // Release A: 1..15, 0 (wrap), 1..10.
        rst_a = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            expect_out(0, k % 16, (k % 16) == 15, k == 16, "count_a");
            wait_neg();
        end

        // Reset between edges at count=10 takes effect without a clock edge.
        #1;
        rst_a = 1'b0;
        #1;
        expect_out(0, 0, 1'b0, 1'b0, "async_reset_a");
        -> sample_ev;
        #1;
        wait_neg();
        expect_out(0, 0, 1'b0, 1'b0, "midreset_hold_a");
        wait_neg();
        rst_a = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            expect_out(0, k, 1'b0, 1'b0, "resume_a");
            wait_neg();
        end

        // Modulus 10: 1..9, 0 (wrap), 1, 2.
        rst_b = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            expect_out(1, k % 10, (k % 10) == 9, k == 10, "mod10_b");
            wait_neg();
        end

        // Reset value 7: 8..15 after release.
        rst_c = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            expect_out(2, 7 + k, (7 + k) == 15, 1'b0, "rv7_c");
            wait_neg();
        end

        // Reset lands on the wrap edge: reset wins.
        @(posedge clk);
        rst_c = 1'b0;
        #1;
        expect_out(2, 7, 1'b0, 1'b0, "reset_on_wrap_c");
        -> sample_ev;
        #1;
        wait_neg();
        expect_out(2, 7, 1'b0, 1'b0, "reset_on_wrap_hold_c");
        wait_neg();
        rst_c = 1'b1;
        expect_out(2, 8, 1'b0, 1'b0, "rv7_restart_c");
        wait_neg();

        wait_neg();
        tests++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
